// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared stage geometry, types and helpers for the adder pipeline controller
package adder_pipe_pkg;

    localparam int NUM_STAGES = 4;
    localparam int STAGE_W    = 8;
    localparam int CNT_W_DEF  = 16;

    typedef logic [1:0] stage_idx_t;

    // Stages 0..k are killed by a flush aimed at stage k
    function automatic logic [NUM_STAGES-1:0] flush_mask(input stage_idx_t k);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STAGES; i++) m[i] = (i <= int'(k));
        return m;
    endfunction

    function automatic logic [2:0] popcount4(input logic [NUM_STAGES-1:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/adder_pipe_stall_inj.sv
// adder_pipe_stall_inj: injected-stall countdown and the per-stage stall mask it produces
module adder_pipe_stall_inj
    import adder_pipe_pkg::*;
#(
    parameter int STALL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inj_req,
    input  logic [1:0]            inj_stage,
    input  logic [STALL_W-1:0]    inj_len,
    output logic                  inj_act,
    output logic [NUM_STAGES-1:0] inj_mask
);

    logic [STALL_W-1:0] inj_cnt_q, inj_cnt_d;
    stage_idx_t         inj_sel_q, inj_sel_d;
    logic               load;

    // New requests are only taken while idle; zero-length requests are dropped
    always_comb begin
        inj_act   = inj_cnt_q != '0;
        load      = inj_req && inj_len != '0 && !inj_act;
        inj_cnt_d = load ? inj_len : inj_act ? inj_cnt_q - STALL_W'(1) : inj_cnt_q;
        inj_sel_d = load ? inj_stage : inj_sel_q;
        inj_mask  = '0;
        for (int i = 0; i < NUM_STAGES; i++) inj_mask[i] = inj_act && inj_sel_q == 2'(i);
    end

    // Countdown and target stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_cnt_q <= '0;
            inj_sel_q <= '0;
        end else begin
            inj_cnt_q <= inj_cnt_d;
            inj_sel_q <= inj_sel_d;
        end
    end

endmodule

// File: rtl/adder_pipe_ctrl.sv
// adder_pipe_ctrl: valid/tag tracking, halt/refresh sequencing and debug counters for the 4-stage adder
module adder_pipe_ctrl
    import adder_pipe_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STALL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_a,
    input  logic [31:0]           in_b,
    input  logic                  in_cin,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_sum,
    output logic                  out_cout,
    output logic [TAG_W-1:0]      out_tag,
    input  logic                  flush_req,
    input  logic [1:0]            flush_stage,
    input  logic                  inj_req,
    input  logic [1:0]            inj_stage,
    input  logic [STALL_W-1:0]    inj_len,
    output logic [31:0]           dp_a,
    output logic [31:0]           dp_b,
    output logic                  dp_cin,
    output logic [NUM_STAGES-1:0] dp_halt,
    output logic [NUM_STAGES-1:0] dp_refresh,
    input  logic [31:0]           dp_sum,
    input  logic                  dp_cout,
    output logic [CNT_W-1:0]      issued_cnt,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      flushed_cnt
);

    logic [NUM_STAGES-1:0]            v_q, v_d;
    logic [NUM_STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]                 issued_q, issued_d;
    logic [CNT_W-1:0]                 retired_q, retired_d;
    logic [CNT_W-1:0]                 flushed_q, flushed_d;
    logic [NUM_STAGES-1:0]            h, f, inj_mask;
    logic                             inj_act;
    logic                             accept, retire;

    adder_pipe_stall_inj #(.STALL_W(STALL_W)) u_stall_inj (
        .clk      (clk),
        .rst_n    (rst_n),
        .inj_req  (inj_req),
        .inj_stage(inj_stage),
        .inj_len  (inj_len),
        .inj_act  (inj_act),
        .inj_mask (inj_mask)
    );

    assign dp_a        = in_a;
    assign dp_b        = in_b;
    assign dp_cin      = in_cin;
    assign out_sum     = dp_sum;
    assign out_cout    = dp_cout;
    assign out_valid   = v_q[3];
    assign out_tag     = tag_q[3];
    assign issued_cnt  = issued_q;
    assign retired_cnt = retired_q;
    assign flushed_cnt = flushed_q;

    // Backpressure ripples toward stage 0 only through occupied stages, so bubbles get squeezed out
    always_comb begin
        f          = flush_req ? flush_mask(flush_stage) : '0;
        h[3]       = (v_q[3] & ~out_ready) | inj_mask[3];
        h[2]       = (v_q[2] & h[3]) | inj_mask[2];
        h[1]       = (v_q[1] & h[2]) | inj_mask[1];
        h[0]       = (v_q[0] & h[1]) | inj_mask[0];
        in_ready   = rst_n & ~h[0] & ~flush_req;
        accept     = in_valid & in_ready;
        retire     = v_q[3] & out_ready & ~f[3];
        dp_halt    = rst_n ? (h & ~f) : '0;
        dp_refresh = rst_n ? f : '1;
    end

    // Stage occupancy and tag movement: flush beats halt, halt beats advance
    always_comb begin
        v_d      = v_q;
        tag_d    = tag_q;
        v_d[0]   = f[0] ? 1'b0 : h[0] ? v_q[0] : in_valid;
        tag_d[0] = (f[0] | h[0]) ? tag_q[0] : in_tag;
        for (int i = 1; i < NUM_STAGES; i++) begin
            v_d[i]   = f[i] ? 1'b0 : h[i] ? v_q[i] : v_q[i-1] & ~h[i-1] & ~f[i-1];
            tag_d[i] = (f[i] | h[i]) ? tag_q[i] : tag_q[i-1];
        end
        issued_d  = issued_q + CNT_W'(accept);
        retired_d = retired_q + CNT_W'(retire);
        flushed_d = flushed_q + CNT_W'(popcount4(v_q & f));
    end

    // Pipeline state and debug counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= '0;
            tag_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            flushed_q <= '0;
        end else begin
            v_q       <= v_d;
            tag_q     <= tag_d;
            issued_q  <= issued_d;
            retired_q <= retired_d;
            flushed_q <= flushed_d;
        end
    end

endmodule

// File: tb/tb_adder_pipe_ctrl.sv
// tb_adder_pipe_ctrl: scoreboard bench with a behavioural 4-stage datapath driven by halt/refresh
module tb_adder_pipe_ctrl;

    localparam int TAG_W   = 4;
    localparam int CNT_W   = 16;
    localparam int STALL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [31:0]        in_a, in_b, out_sum, dp_a, dp_b, dp_sum;
    logic [TAG_W-1:0]   in_tag, out_tag;
    logic               flush_req, inj_req, dp_cin, dp_cout;
    logic [1:0]         flush_stage, inj_stage;
    logic [STALL_W-1:0] inj_len;
    logic [3:0]         dp_halt, dp_refresh;
    logic [CNT_W-1:0]   issued_cnt, retired_cnt, flushed_cnt;

    logic [3:0][32:0]   dpr;
    logic [36:0]        sb[$];
    logic [36:0]        e;
    int                 errs = 0, checks = 0;
    int                 kill_n = 0, bub = 0;
    logic               bub_en = 1'b0, seen = 1'b0;

    always #5 clk = ~clk;

    adder_pipe_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_tag(out_tag), .flush_req(flush_req), .flush_stage(flush_stage),
        .inj_req(inj_req), .inj_stage(inj_stage), .inj_len(inj_len),
        .dp_a(dp_a), .dp_b(dp_b), .dp_cin(dp_cin), .dp_halt(dp_halt), .dp_refresh(dp_refresh),
        .dp_sum(dp_sum), .dp_cout(dp_cout),
        .issued_cnt(issued_cnt), .retired_cnt(retired_cnt), .flushed_cnt(flushed_cnt)
    );

    // Behavioural datapath: whole sum formed in stage 0, then carried through halt/refresh-controlled stages
    always @(posedge clk) begin
        if (dp_refresh[0]) dpr[0] <= '0;
        else if (!dp_halt[0]) dpr[0] <= {1'b0, dp_a} + {1'b0, dp_b} + {32'b0, dp_cin};
        for (int i = 1; i < 4; i++)
            if (dp_refresh[i]) dpr[i] <= '0;
            else if (!dp_halt[i]) dpr[i] <= dpr[i-1];
    end
    assign dp_sum  = dpr[3][31:0];
    assign dp_cout = dpr[3][32];

    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic [TAG_W-1:0] t);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b} + {32'b0, c};
        return {s, t};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill4(input logic [TAG_W-1:0] t0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            in_cin = 1'($urandom);
            in_tag = t0 + TAG_W'(i);
            @(negedge clk);
            chk("fill_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: push on accept, pop on retire, drop killed entries on flush, clear on reset
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (bub_en) begin
                if (out_valid) seen = 1'b1;
                else if (seen && sb.size() != 0) bub++;
            end
            if (out_valid && out_ready && !(flush_req && flush_stage == 2'd3)) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("result", {out_cout, out_sum, out_tag}, e);
                end
            end
            if (flush_req)
                for (int i = 0; i < kill_n; i++) if (sb.size() != 0) void'(sb.pop_back());
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_cin, in_tag));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_tag = 0; out_ready = 0;
        flush_req = 0; flush_stage = 0; inj_req = 0; inj_stage = 0; inj_len = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_halt", dp_halt, 4'h0);
        chk("rst_refresh", dp_refresh, 4'hF);
        chk("rst_cnt", {issued_cnt, retired_cnt, flushed_cnt}, 0);
        @(posedge clk);
        #1 rst_n = 1;

        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = i < 8;
            in_a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            in_b = (i == 0) ? 32'd1 : $urandom;
            in_cin = (i == 0) ? 1'b0 : 1'($urandom);
            in_tag = TAG_W'(i);
            @(negedge clk);
            if (i < 8) chk("t1_ready", in_ready, 1);
            chk("t1_valid", out_valid, i >= 4);
            if (i >= 4) chk("t1_tag", out_tag, i - 4);
            if (i == 4) chk("t1_first", {out_cout, out_sum}, 33'h1_0000_0000);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("t1_issued", issued_cnt, 8);
        chk("t1_retired", retired_cnt, 8);

        fill4(4'hA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_halt", dp_halt, 4'hF);
            chk("t2_ready", in_ready, 0);
            chk("t2_valid", out_valid, 1);
            chk("t2_tag", out_tag, 4'hA);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("t2_issued", issued_cnt, 12);
        chk("t2_retired", retired_cnt, 12);

        bub_en = 1'b1;
        inj_stage = 2'd1;
        inj_len = 4'd2;
        for (int j = 0; j < 12; j++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            in_cin = 1'($urandom);
            in_tag = TAG_W'(j);
            inj_req = (j == 5);
            @(negedge clk);
            chk("t3_halt", dp_halt, (j == 6 || j == 7) ? 4'b0011 : 4'b0000);
            chk("t3_ready", in_ready, !(j == 6 || j == 7));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        inj_req = 1'b0;
        drain();
        bub_en = 1'b0;
        chk("t3_bubbles", bub, 2);
        chk("t3_issued", issued_cnt, 22);
        chk("t3_retired", retired_cnt, 22);

        fill4(4'h0);
        flush_req = 1'b1;
        flush_stage = 2'd2;
        kill_n = 3;
        in_valid = 1'b1;
        in_tag = 4'hF;
        @(negedge clk);
        chk("t4_refresh", dp_refresh, 4'b0111);
        chk("t4_halt", dp_halt, 4'b1000);
        chk("t4_ready", in_ready, 0);
        @(posedge clk);
        #1 flush_req = 1'b0; kill_n = 0; in_valid = 1'b0;
        chk("t4_flushed", flushed_cnt, 3);
        chk("t4_issued", issued_cnt, 26);
        out_ready = 1'b1;
        drain();
        chk("t4_retired", retired_cnt, 23);
        repeat (3) begin
            @(negedge clk);
            chk("t4_empty", out_valid, 0);
        end
        @(posedge clk);
        #1;

        fill4(4'h4);
        flush_req = 1'b1;
        flush_stage = 2'd3;
        kill_n = 4;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_refresh", dp_refresh, 4'hF);
        chk("t5_halt", dp_halt, 4'h0);
        @(posedge clk);
        #1 flush_req = 1'b0; kill_n = 0;
        chk("t5_flushed", flushed_cnt, 7);
        chk("t5_retired", retired_cnt, 23);
        chk("t5_issued", issued_cnt, 30);
        chk("t5_sb", sb.size(), 0);
        @(negedge clk);
        chk("t5_empty", out_valid, 0);

        @(posedge clk);
        #1;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            in_cin = 1'($urandom);
            in_tag = TAG_W'(j);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_refresh", dp_refresh, 4'hF);
        chk("t6_halt", dp_halt, 4'h0);
        chk("t6_ready", in_ready, 0);
        chk("t6_cnt", {issued_cnt, retired_cnt, flushed_cnt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_a = 32'h1234_5678;
        in_b = 32'h0FED_CBA9;
        in_cin = 1'b1;
        in_tag = 4'h5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("t6_issued", issued_cnt, 1);
        chk("t6_retired", retired_cnt, 1);
        chk("t6_flushed", flushed_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/adder_pipe_ctrl.md
Name: adder_pipe_ctrl

Overview:
- Sequencing controller for the 4-stage, 8-bit-per-stage 32-bit pipelined adder datapath.
- Accepts operand requests over a valid/ready handshake and tracks a valid bit and tag per stage.
- Drives the datapath's per-stage halt[3:0] and refresh[3:0] for backpressure, injected stalls and flushes.
- Presents results with valid/ready and keeps issue, retire and flush counters for debug.

Parameters:
- TAG_W, 4: width of the request tag carried alongside each operand pair.
- CNT_W, 16: width of the issued/retired/flushed counters; counters wrap modulo 2^CNT_W.
- STALL_W, 4: width of the injected-stall length field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller accepts a request this cycle.
- in_a  in  32  operand a.
- in_b  in  32  operand b.
- in_cin  in  1  carry-in.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid (stage 3 occupied).
- out_ready  in  1  consumer accepts the result.
- out_sum  out  32  result, passed from dp_sum.
- out_cout  out  1  carry-out, passed from dp_cout.
- out_tag  out  TAG_W  tag of the stage-3 entry.
- flush_req  in  1  flush pulse.
- flush_stage  in  2  k: flush stages 0..k.
- inj_req  in  1  start an injected stall.
- inj_stage  in  2  stage to stall.
- inj_len  in  STALL_W  stall length in cycles; 0 is ignored.
- dp_a  out  32  to datapath operand a (= in_a).
- dp_b  out  32  to datapath operand b (= in_b).
- dp_cin  out  1  to datapath carry-in (= in_cin).
- dp_halt  out  4  to datapath halt; 1 = stage i holds its registers.
- dp_refresh  out  4  to datapath refresh; 1 = stage i clears its registers.
- dp_sum  in  32  from datapath sum output.
- dp_cout  in  1  from datapath carry output.
- issued_cnt  out  CNT_W  accepted request count.
- retired_cnt  out  CNT_W  delivered result count.
- flushed_cnt  out  CNT_W  count of valid entries killed by flush.

Behaviour:
- Reset (rst_n low, async):
  - v[3:0]=0, tags=0, counters=0, injected-stall counter=0.
  - out_valid=0, in_ready=0, dp_halt=0, dp_refresh=4'b1111 while rst_n is low.
- Halt chain (combinational):
  - inj_act = (inj_cnt!=0).
  - h[3] = v[3]&!out_ready | (inj_act & inj_sel==3).
  - h[i] = v[i]&h[i+1] | (inj_act & inj_sel==i), for i<3.
  - dp_halt = h.
  - Stall propagates only into occupied younger stages; bubbles are compressed.
- Flush:
  - When flush_req is high, kill mask f[i] = (i<=flush_stage); otherwise f=0.
  - dp_refresh = f.
  - f overrides h for the flushed stages (dp_halt[i]=h[i]&!f[i]).
- Advance per edge, i>0:
  - f[i]: v[i]<=0.
  - else h[i]: hold v[i] and tag.
  - else v[i]<=v[i-1]&!h[i-1]&!f[i-1], and tag shifts.
- Stage 0 advance:
  - f[0]: v[0]<=0.
  - else h[0]: hold.
  - else v[0]<=in_valid, tag[0]<=in_tag.
- Handshake:
  - in_ready = rst_n & !h[0] & !flush_req.
  - Accept on in_valid&in_ready.
  - out_valid=v[3].
  - Retire on v[3]&out_ready&!f[3].
  - out_sum/out_cout are meaningful only while out_valid=1.
- Latency: a request accepted at edge k shows out_valid=1 after edge k+3 when no stalls occur. Throughput is 1 per cycle.
- Injected stall:
  - inj_req with inj_len!=0 while inj_act=0 loads inj_cnt=inj_len and inj_sel=inj_stage.
  - inj_cnt decrements once per cycle to 0.
  - inj_req while inj_act=1 is ignored.
- Counters:
  - issued_cnt +1 per accept.
  - retired_cnt +1 per retire.
  - flushed_cnt += popcount(v&f).
  - Counters wrap.
- Simultaneous events:
  - flush and accept: accept blocked.
  - flush and retire of stage 3: entry is counted flushed, not retired.
  - A flush does not cancel an active injected stall.
- Mid-operation reset: all in-flight entries are discarded with no out_valid, and counters are cleared.

Decomposition:
- Shared package adder_pipe_pkg:
  - NUM_STAGES=4 and STAGE_W=8.
  - Stage index type (2-bit).
  - Counter width default.
- One natural sub-module, adder_pipe_stall_inj: the inj_cnt/inj_sel countdown and the per-stage inject mask.

Test Plan:
- Reset, then stream of 8 accepts with out_ready=1 (a=32'hFFFF_FFFF, b=1, cin=0 first) -> out_sum=0 and out_cout=1 after 4 edges; back-to-back out_valid; tags 0..7 in order; issued=retired=8.
- 4 accepts, then out_ready=0 for 3 cycles -> dp_halt=4'b1111; in_ready=0; results held with tags unchanged; on release all four delivered in order.
- Inject stall inj_stage=1, inj_len=2 during a full stream -> dp_halt=4'b0011 for 2 cycles; stages 2/3 drain; exactly 2 bubbles appear at output; no loss or duplication.
- Pipeline full, flush_req with flush_stage=2 -> dp_refresh=4'b0111; only the stage-3 entry retires; flushed_cnt=3; in_ready=0 during the flush cycle.
- Flush and out_ready coincide with flush_stage=3 -> no retire, flushed_cnt counts stage 3.
- Assert rst_n low mid-stream for one cycle -> out_valid=0 immediately; counters=0; dp_refresh=4'b1111 during reset; clean restart on the next accept.
